// File: rtl/xbus_gpio_pkg.sv
// xbus_gpio_pkg: xbus width macros, GPIO register offsets and register index type
`ifndef XBUS_CONFIG_VH
`define XBUS_CONFIG_VH
`define XADDRW 32
`define XDATAW 32
`define XBYTEC 4
`define GPIO_IN   3'd0
`define GPIO_OUT  3'd1
`define GPIO_SET  3'd2
`define GPIO_CLR  3'd3
`define GPIO_EDGE 3'd4
`define GPIO_IEN  3'd5
`endif

package xbus_gpio_pkg;
  typedef enum logic [2:0] {
    REG_IN   = `GPIO_IN,
    REG_OUT  = `GPIO_OUT,
    REG_SET  = `GPIO_SET,
    REG_CLR  = `GPIO_CLR,
    REG_EDGE = `GPIO_EDGE,
    REG_IEN  = `GPIO_IEN,
    REG_RSV6 = 3'd6,
    REG_RSV7 = 3'd7
  } reg_e;
  function automatic logic [`XDATAW-1:0] be_mask(input logic [`XBYTEC-1:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/xbus_gpio_debounce.sv
// gpio_debounce: 2-flop synchroniser plus optional tick-sampled debouncer (GPIO_DEBOUNCE_EN)
// Ports: clk, rst_n (async active-low), din (async pins), in_db (debounced value)
module gpio_debounce #(
  parameter int IN_W      = 8,
  parameter int DB_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] din,
  output logic [IN_W-1:0] in_db
);
  logic [IN_W-1:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2} <= '0;
    else {s1, s2} <= {din, s1};
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  logic [CW-1:0] cnt;
  logic [IN_W-1:0] prev, diff;
  logic tick;
  assign tick = cnt == CW'(DB_CYCLES - 1);
  assign diff = s2 ^ prev;
  // a bit is accepted only when two consecutive tick samples agree
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      prev  <= '0;
      in_db <= '0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      prev  <= tick ? s2 : prev;
      in_db <= tick ? (s2 & ~diff) | (in_db & diff) : in_db;
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_db <= '0;
    else in_db <= s2;
`endif
endmodule

// File: rtl/xbus_gpio.sv
// xbus_gpio: xbus GPIO slave with set/clear outputs, sticky rising-edge flags and level irq
// Ports: clk, rst_n (async active-low); xbus_cs/we/be/addr/wdata/rdata slave bus;
// gpio_in (async pins), gpio_out (registered), irq (registered). Debounce via GPIO_DEBOUNCE_EN.
module xbus_gpio
  import xbus_gpio_pkg::*;
#(
  parameter int               IN_W      = 8,
  parameter int               OUT_W     = 8,
  parameter int               DB_CYCLES = 50000,
  parameter logic [OUT_W-1:0] OUT_RST   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                xbus_cs,
  input  logic                xbus_we,
  input  logic [`XBYTEC-1:0]  xbus_be,
  input  logic [`XADDRW-1:0]  xbus_addr,
  input  logic [`XDATAW-1:0]  xbus_wdata,
  output logic [`XDATAW-1:0]  xbus_rdata,
  input  logic [IN_W-1:0]     gpio_in,
  output logic [OUT_W-1:0]    gpio_out,
  output logic                irq
);
  logic [IN_W-1:0] in_db, in_db_q, edge_q, ien, edge_clr;
  logic [OUT_W-1:0] out_n;
  logic [`XDATAW-1:0] bm, wd;
  logic wr, unused_ok;
  reg_e ra;
  gpio_debounce #(.IN_W(IN_W), .DB_CYCLES(DB_CYCLES)) u_db (
    .clk(clk), .rst_n(rst_n), .din(gpio_in), .in_db(in_db)
  );
  assign ra        = reg_e'(xbus_addr[4:2]);
  assign wr        = xbus_cs & xbus_we;
  assign bm        = be_mask(xbus_be);
  assign wd        = xbus_wdata & bm;
  assign edge_clr  = (wr && ra == REG_EDGE) ? wd[IN_W-1:0] : '0;
  assign unused_ok = ^{xbus_addr, xbus_wdata, wd, bm};
  always_comb
    out_n = !wr                ? gpio_out :
            ra == REG_OUT      ? (gpio_out & ~bm[OUT_W-1:0]) | wd[OUT_W-1:0] :
            ra == REG_SET      ? gpio_out | wd[OUT_W-1:0] :
            ra == REG_CLR      ? gpio_out & ~wd[OUT_W-1:0] : gpio_out;
  // in_db_q resets to 0 so a pin held high through reset still flags a rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gpio_out <= OUT_RST;
      in_db_q  <= '0;
      edge_q   <= '0;
      ien      <= '0;
      irq      <= 1'b0;
    end else begin
      gpio_out <= out_n;
      in_db_q  <= in_db;
      edge_q   <= (edge_q & ~edge_clr) | (in_db & ~in_db_q);
      ien      <= (wr && ra == REG_IEN) ? (ien & ~bm[IN_W-1:0]) | wd[IN_W-1:0] : ien;
      irq      <= |(edge_q & ien);
    end
  always_comb
    xbus_rdata = ra == REG_IN                                       ? `XDATAW'(in_db) :
                 (ra == REG_OUT || ra == REG_SET || ra == REG_CLR) ? `XDATAW'(gpio_out) :
                 ra == REG_EDGE                                     ? `XDATAW'(edge_q) :
                 ra == REG_IEN                                      ? `XDATAW'(ien) : '0;
endmodule

// File: doc/xbus_gpio.md
# xbus_gpio

Parametrised general-purpose I/O peripheral on the xbus, replacing the fixed 8-switch/8-LED port. Provides up to 32 synchronised and optionally debounced inputs, up to 32 outputs with atomic set/clear, sticky rising-edge flags, and a level interrupt. It sits beside the other xbus slaves and drives board switches, buttons and LEDs.

## Interface
- IN_W, 8, number of input pins (1..32)
- OUT_W, 8, number of output pins (1..32)
- DB_CYCLES, 50000, debounce sample period in clk cycles (≥2)
- OUT_RST, 0, reset value of the output register (OUT_W bits)
- clk  input  1  system clock; all state is updated on the rising edge
- rst_n  input  1  asynchronous active-low reset
- xbus_cs  input  1  slave select
- xbus_we  input  1  write strobe, qualified by xbus_cs
- xbus_be  input  `XBYTEC  byte enables for writes
- xbus_addr  input  `XADDRW  byte address; only bits [4:2] are decoded
- xbus_wdata  input  `XDATAW  write data
- xbus_rdata  output  `XDATAW  read data
- gpio_in  input  IN_W  asynchronous pin inputs
- gpio_out  output  OUT_W  registered pin outputs
- irq  output  1  level interrupt, registered

## Operation
- Register map, word offsets:
  - 0x00 IN (RO): debounced inputs.
  - 0x04 OUT (RW): byte-enable masked write.
  - 0x08 OUT_SET (WO): OUT |= wdata. Reads return OUT.
  - 0x0C OUT_CLR (WO): OUT &= ~wdata. Reads return OUT.
  - 0x10 EDGE (RW1C): sticky rising-edge flags. A 1 clears the flag; byte-enable masked.
  - 0x14 IRQ_EN (RW): byte-enable masked.
  - 0x18 and 0x1C read 0, and writes to them are ignored.
- All write operations require xbus_cs & xbus_we. OUT_SET and OUT_CLR also honour xbus_be per byte.
- Unused upper bits read as 0, and writes to them are dropped.
- Input path: 2-flop synchroniser, then the debouncer (see Configuration), then the debounced value `in_db`.
- EDGE[i] is set when `in_db[i]` goes from 0 to 1. In the same cycle, set wins over a W1C clear.
- irq is registered as |(EDGE & IRQ_EN).
- Reset values:
  - gpio_out = OUT_RST.
  - Synchroniser stages, in_db, EDGE, IRQ_EN and irq are all 0.
  - An input held high through reset raises its EDGE flag once it propagates.
- Reset asserted mid-debounce discards the partial count.

## Timing
- Reads are combinational from registered state: xbus_rdata is valid in the same cycle as xbus_cs. There are no wait states.
- Writes take effect at the clk edge. gpio_out changes one cycle after the write cycle.
- Without debounce, a pin change reaches IN after 3 edges (2 sync flops + in_db).
- EDGE is set on the edge after the in_db rise. irq asserts one edge later.
- With debounce, a change is accepted only at a sample tick, and only if the synchronised value was equal at two consecutive ticks. Worst-case acceptance is 2·DB_CYCLES + 3 cycles.
- W1C of EDGE deasserts irq on the second edge after the write, unless another edge re-sets the flag.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - A shared counter counts 0..DB_CYCLES-1 and produces a one-cycle tick when it wraps.
  - Each bit keeps its previous-tick sample. At a tick, in_db[i] loads the sample if the current sample equals the previous one.
- GPIO_DEBOUNCE_EN undefined:
  - The counter and sample registers are not generated.
  - in_db loads the synchroniser output every cycle.
  - DB_CYCLES is ignored.

## Structure
- Register offsets (`GPIO_IN`, `GPIO_OUT`, `GPIO_SET`, `GPIO_CLR`, `GPIO_EDGE`, `GPIO_IEN`) are defined in the shared config.vh beside the xbus width macros, so software headers and other slaves share them.
- One sub-module, gpio_debounce, parametrised by IN_W and DB_CYCLES. It contains the synchroniser, the tick counter and the sample registers, and outputs in_db.
- The register file and bus decode stay in xbus_gpio.

## Test plan
- Reset with OUT_RST=8'hA5 → gpio_out=8'hA5, irq=0, and reads of IN, EDGE and IRQ_EN return 0.
- Write OUT=32'h0000_00F0 with be=4'b0001, then SET 32'h3, then CLR 32'h10 → gpio_out=8'hE3. A write with be=4'b0000 leaves gpio_out unchanged.
- Without debounce: IRQ_EN=1 and gpio_in[0] goes 0→1 → IN bit0 is set after 3 edges and EDGE=1 at the next edge. Then irq=1. W1C EDGE=1 → irq=0 two edges later.
- W1C to EDGE bit0 in the same cycle as a new in_db rise on bit0 → EDGE bit0 stays 1.
- With GPIO_DEBOUNCE_EN and DB_CYCLES=4: a 3-cycle glitch on gpio_in[1] → IN unchanged. A level held for 12 cycles → IN bit1 is set within 11 cycles of the change.
- Read offset 0x18 → 0. Write 32'hFFFF_FFFF to IRQ_EN with IN_W=8 → reads 32'h0000_00FF.
